// File: rtl/dht11_responder_if.sv
// Payload, control and status bundle between the DHT11 responder and its host side.
// The open-drain data pin stays a plain port so it can be wired as a tristate net.
interface dht11_responder_if;
    logic       enable;
    logic [7:0] hum_int;
    logic [7:0] hum_dec;
    logic [7:0] temp_int;
    logic [7:0] temp_dec;
    logic       corrupt_checksum;
    logic       busy;
    logic       frame_done;
    logic       drive_low;

    modport master (
        output enable, hum_int, hum_dec, temp_int, temp_dec, corrupt_checksum,
        input  busy, frame_done, drive_low
    );

    modport slave (
        input  enable, hum_int, hum_dec, temp_int, temp_dec, corrupt_checksum,
        output busy, frame_done, drive_low
    );
endinterface

// File: rtl/dht11_responder.sv
// DHT11 device emulator: detects a host start pulse, answers with the presence
// sequence and shifts out a 40-bit humidity/temperature frame on an open-drain line.
module dht11_responder #(
    parameter int CYCLES_PER_US = 10,
    parameter int START_MIN_US  = 1000,
    parameter int RESP_DELAY_US = 30
) (
    input  logic               clk,
    input  logic               rst,
    inout  wire                dht_data,
    dht11_responder_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_START_LOW, S_RESP_DELAY, S_RESP_LOW,
        S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH, S_END_LOW
    } state_t;

    localparam logic [31:0] L_START = 32'(START_MIN_US * CYCLES_PER_US);
    localparam logic [31:0] L_DELAY = 32'(RESP_DELAY_US * CYCLES_PER_US);
    localparam logic [31:0] L_PRES  = 32'(80 * CYCLES_PER_US);
    localparam logic [31:0] L_BLOW  = 32'(50 * CYCLES_PER_US);
    localparam logic [31:0] L_ZERO  = 32'(26 * CYCLES_PER_US);
    localparam logic [31:0] L_ONE   = 32'(70 * CYCLES_PER_US);
    localparam logic [31:0] L_END   = 32'(50 * CYCLES_PER_US);

    state_t      r_state, w_state_nx;
    logic [1:0]  r_sync;
    logic        w_din_s;
    logic [31:0] r_cnt, w_cnt_nx;
    logic [5:0]  r_bit, w_bit_nx;
    logic [39:0] r_shift, w_shift_nx;
    logic        r_drive_low, w_drive_nx;
    logic        r_frame_done, w_done_nx;
    logic [7:0]  w_sum, w_chk;
    logic [31:0] w_len;
    logic        w_last;

    assign w_din_s  = r_sync[1];
    assign dht_data = r_drive_low ? 1'b0 : 1'bz;
    assign w_sum    = bus.hum_int + bus.hum_dec + bus.temp_int + bus.temp_dec;
    assign w_chk    = bus.corrupt_checksum ? ~w_sum : w_sum;

    always_comb begin
        w_len = L_END;
        case (r_state)
            S_RESP_DELAY: w_len = L_DELAY;
            S_RESP_LOW:   w_len = L_PRES;
            S_RESP_HIGH:  w_len = L_PRES;
            S_BIT_LOW:    w_len = L_BLOW;
            S_BIT_HIGH:   w_len = r_shift[39] ? L_ONE : L_ZERO;
            default:      w_len = L_END;
        endcase
    end

    assign w_last = (r_cnt == w_len - 32'd1);

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt + 32'd1;
        w_bit_nx   = r_bit;
        w_shift_nx = r_shift;
        w_done_nx  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nx = '0;
                if (bus.enable && !w_din_s) w_state_nx = S_START_LOW;
            end
            S_START_LOW: begin
                if (!w_din_s) begin
                    // saturate so a stuck-low line cannot wrap the counter
                    if (r_cnt >= L_START) w_cnt_nx = r_cnt;
                end else begin
                    w_cnt_nx = '0;
                    if (r_cnt >= L_START) begin
                        w_state_nx = S_RESP_DELAY;
                        w_shift_nx = {bus.hum_int, bus.hum_dec,
                                      bus.temp_int, bus.temp_dec, w_chk};
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end
            end
            S_RESP_DELAY: if (w_last) begin
                w_state_nx = S_RESP_LOW;
                w_cnt_nx   = '0;
            end
            S_RESP_LOW: if (w_last) begin
                w_state_nx = S_RESP_HIGH;
                w_cnt_nx   = '0;
            end
            S_RESP_HIGH: if (w_last) begin
                w_state_nx = S_BIT_LOW;
                w_cnt_nx   = '0;
                w_bit_nx   = '0;
            end
            S_BIT_LOW: if (w_last) begin
                w_state_nx = S_BIT_HIGH;
                w_cnt_nx   = '0;
            end
            S_BIT_HIGH: if (w_last) begin
                w_cnt_nx   = '0;
                w_shift_nx = {r_shift[38:0], 1'b0};
                w_bit_nx   = r_bit + 6'd1;
                w_state_nx = (r_bit == 6'd39) ? S_END_LOW : S_BIT_LOW;
            end
            S_END_LOW: if (w_last) begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = '0;
                w_done_nx  = 1'b1;
            end
            default: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    assign w_drive_nx = (w_state_nx == S_RESP_LOW) ||
                        (w_state_nx == S_BIT_LOW)  ||
                        (w_state_nx == S_END_LOW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync       <= 2'b11;
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_drive_low  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_sync       <= {r_sync[0], dht_data};
            r_state      <= w_state_nx;
            r_cnt        <= w_cnt_nx;
            r_bit        <= w_bit_nx;
            r_shift      <= w_shift_nx;
            r_drive_low  <= w_drive_nx;
            r_frame_done <= w_done_nx;
        end
    end

    assign bus.busy       = (r_state != S_IDLE) && (r_state != S_START_LOW);
    assign bus.frame_done = r_frame_done;
    assign bus.drive_low  = r_drive_low;
endmodule

// File: tb/tb_dht11_responder.sv
// Bench for dht11_responder: plays the host on the open-drain line and decodes
// the responder's pulse train back into bytes against a frame model.
module tb_dht11_responder;
    localparam int CPU  = 2;
    localparam int SMIN = 100;
    localparam int RDLY = 30;
    localparam int LIM  = 2000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic r_host_low = 1'b0;
    wire  dht_data;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] r_nh, r_nhd, r_nt, r_ntd;

    dht11_responder_if bus();

    pullup (dht_data);
    assign dht_data = r_host_low ? 1'b0 : 1'bz;

    dht11_responder #(
        .CYCLES_PER_US(CPU),
        .START_MIN_US (SMIN),
        .RESP_DELAY_US(RDLY)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .dht_data(dht_data),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [39:0] model_frame(input int h, input int hd,
                                                input int t, input int td,
                                                input bit bad);
        int s;
        s = (h + hd + t + td) % 256;
        if (bad) s = 255 - s;
        return {8'(h), 8'(hd), 8'(t), 8'(td), 8'(s)};
    endfunction

    task automatic set_payload(input int h, input int hd, input int t,
                               input int td, input bit bad);
        bus.hum_int          = 8'(h);
        bus.hum_dec          = 8'(hd);
        bus.temp_int         = 8'(t);
        bus.temp_dec         = 8'(td);
        bus.corrupt_checksum = bad;
    endtask

    task automatic host_pulse(input int us);
        @(negedge clk);
        r_host_low = 1'b1;
        repeat (us * CPU) @(negedge clk);
        r_host_low = 1'b0;
    endtask

    task automatic measure_run(input logic lvl, output int len);
        len = 0;
        while (bus.drive_low === lvl && len < LIM) begin
            @(negedge clk);
            len++;
        end
    endtask

    task automatic capture_frame(input logic [39:0] exp, input string nm,
                                 input int chg_bit, input bit drop_en);
        int lat, len, terr, first_bad;
        logic [39:0] got;
        terr = 0;
        first_bad = -1;
        got = '0;
        lat = 0;
        while (bus.drive_low !== 1'b1 && lat < LIM) begin
            @(negedge clk);
            lat++;
            if (lat == 10) begin
                checks++;
                if (bus.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy_in_delay got=%b exp=1", nm, bus.busy);
                end
            end
        end
        checks++;
        if (lat != 3 + RDLY * CPU) begin
            errors++;
            $display("FAIL %s latency got=%0d exp=%0d", nm, lat, 3 + RDLY * CPU);
            return;
        end
        checks++;
        if (dht_data !== 1'b0) begin
            errors++;
            $display("FAIL %s line_low got=%b exp=0", nm, dht_data);
        end
        if (drop_en) bus.enable = 1'b0;
        measure_run(1'b1, len);
        if (len != 80 * CPU) begin terr++; first_bad = 100; end
        measure_run(1'b0, len);
        if (len != 80 * CPU) begin terr++; first_bad = 101; end
        for (int i = 0; i < 40; i++) begin
            if (i == chg_bit) set_payload(r_nh, r_nhd, r_nt, r_ntd, bus.corrupt_checksum);
            measure_run(1'b1, len);
            if (len != 50 * CPU) begin terr++; if (first_bad < 0) first_bad = i; end
            measure_run(1'b0, len);
            if (len == 70 * CPU) got[39-i] = 1'b1;
            else if (len == 26 * CPU) got[39-i] = 1'b0;
            else begin terr++; if (first_bad < 0) first_bad = i; end
            if (len >= LIM) break;
        end
        measure_run(1'b1, len);
        if (len != 50 * CPU) begin terr++; first_bad = 102; end
        checks++;
        if (terr != 0) begin
            errors++;
            $display("FAIL %s pulse_timing bad_runs=%0d first_at=%0d exp=0", nm, terr, first_bad);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (got[39-8*k -: 8] !== exp[39-8*k -: 8]) begin
                errors++;
                $display("FAIL %s byte%0d got=%02h exp=%02h", nm, k,
                         got[39-8*k -: 8], exp[39-8*k -: 8]);
            end
        end
        checks++;
        if (bus.frame_done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done_edge got done=%b busy=%b exp done=1 busy=0",
                     nm, bus.frame_done, bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse_width got=%b exp=0", nm, bus.frame_done);
        end
        bus.enable = 1'b1;
    endtask

    task automatic expect_silence(input string nm, input int cyc);
        int hits;
        hits = 0;
        repeat (cyc) begin
            @(negedge clk);
            if (bus.drive_low !== 1'b0 || bus.busy !== 1'b0) hits++;
        end
        checks++;
        if (hits != 0) begin
            errors++;
            $display("FAIL %s silent got_active_cycles=%0d exp=0", nm, hits);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (bus.drive_low !== 1'b0) begin
            errors++; $display("FAIL reset_drive got=%b exp=0", bus.drive_low);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy);
        end
        checks++;
        if (bus.frame_done !== 1'b0) begin
            errors++; $display("FAIL reset_done got=%b exp=0", bus.frame_done);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_nominal();
        set_payload(8'h37, 8'h00, 8'h16, 8'h00, 1'b0);
        host_pulse(180);
        capture_frame(40'h37_00_16_00_4D, "nominal", -1, 1'b0);
    endtask

    task automatic test_back_to_back_corrupt();
        set_payload(8'h37, 8'h00, 8'h16, 8'h00, 1'b1);
        host_pulse(180);
        capture_frame(40'h37_00_16_00_B2, "corrupt", -1, 1'b0);
        bus.corrupt_checksum = 1'b0;
    endtask

    task automatic test_overflow();
        set_payload(8'hFF, 8'hFF, 8'h02, 8'h03, 1'b0);
        host_pulse(180);
        capture_frame(40'hFF_FF_02_03_03, "overflow_en_drop", -1, 1'b1);
    endtask

    task automatic test_short_pulse();
        host_pulse(50);
        expect_silence("short_pulse", 300);
    endtask

    task automatic test_enable_low();
        bus.enable = 1'b0;
        host_pulse(180);
        expect_silence("enable_low", 300);
        bus.enable = 1'b1;
    endtask

    task automatic test_payload_change();
        int h, hd, t, td;
        bit bad;
        h = int'($urandom_range(0, 255)); hd = int'($urandom_range(0, 255));
        t = int'($urandom_range(0, 255)); td = int'($urandom_range(0, 255));
        bad = 1'($urandom_range(0, 1));
        set_payload(h, hd, t, td, bad);
        r_nh = 8'($urandom); r_nhd = 8'($urandom);
        r_nt = 8'($urandom); r_ntd = 8'($urandom);
        host_pulse(180);
        capture_frame(model_frame(h, hd, t, td, bad), "change_old", 10, 1'b0);
        host_pulse(180);
        capture_frame(model_frame(int'(r_nh), int'(r_nhd), int'(r_nt), int'(r_ntd), bad),
                      "change_new", -1, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        int lat, h, hd, t, td;
        set_payload(8'hA5, 8'h5A, 8'h3C, 8'hC3, 1'b0);
        host_pulse(180);
        lat = 0;
        while (bus.drive_low !== 1'b1 && lat < LIM) begin
            @(negedge clk);
            lat++;
        end
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.drive_low !== 1'b0 || dht_data !== 1'b1) begin
            errors++;
            $display("FAIL async_release got drive=%b line=%b exp drive=0 line=1",
                     bus.drive_low, dht_data);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs got busy=%b done=%b exp 0/0",
                     bus.busy, bus.frame_done);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        expect_silence("after_reset", 200);
        h = int'($urandom_range(0, 255)); hd = int'($urandom_range(0, 255));
        t = int'($urandom_range(0, 255)); td = int'($urandom_range(0, 255));
        set_payload(h, hd, t, td, 1'b0);
        host_pulse(180);
        capture_frame(model_frame(h, hd, t, td, 1'b0), "post_reset", -1, 1'b0);
    endtask

    initial begin
        bus.enable = 1'b1;
        set_payload(0, 0, 0, 0, 1'b0);
        r_nh = '0; r_nhd = '0; r_nt = '0; r_ntd = '0;
        test_reset();
        test_nominal();
        test_back_to_back_corrupt();
        test_short_pulse();
        test_enable_low();
        test_overflow();
        test_payload_change();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
